axi_sram_slave: RTL

- AXI4 responder (slave end) that fronts a single-port 32-bit SRAM macro. It is the counterpart of the DMA/CPU masters on the interconnect.
- Accepts INCR/FIXED bursts on AW/W/B and AR/R and converts each beat into SRAM chip-select/byte-write cycles.
- Handles one transaction at a time, read or write, with fair arbitration when both request together.
- Instantiated once per SRAM slave port behind the AXI bridge.

---
 rtl/axi_sram_slave_pkg.sv | 50 +++++
 rtl/axi_burst_addr_gen.sv | 56 +++++
 rtl/axi_sram_slave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_pkg.sv
// axi_sram_slave_pkg
// Shared definitions for the AXI SRAM responder: AXI width macros (guarded,
// so the project-wide define file wins when it is present), response and
// burst encodings, and the responder FSM state type.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_sram_slave_pkg;

  localparam int AXI_ID_W   = `AXI_IDS_BITS;
  localparam int AXI_ADDR_W = `AXI_ADDR_BITS;
  localparam int AXI_LEN_W  = `AXI_LEN_BITS;
  localparam int AXI_SIZE_W = `AXI_SIZE_BITS;
  localparam int AXI_DATA_W = `AXI_DATA_BITS;
  localparam int AXI_STRB_W = `AXI_STRB_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen
// Holds the burst context of the transaction in flight (word address, length,
// FIXED/INCR behaviour) plus the beat counter, and flags the final beat.
// Shared by the read and write paths since only one transaction runs at a time.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         latch a new burst (address, len, burst type), counter to 0
//   load_*       burst context captured on load
//   advance      step to the next beat (address + 1 unless FIXED, count + 1)
//   addr         current SRAM word address
//   cnt          current beat index
//   last         current beat is the final one (cnt == len)
module axi_burst_addr_gen
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [MEM_AW-1:0]    load_addr,
  input  logic [AXI_LEN_W-1:0] load_len,
  input  logic [1:0]           load_burst,
  input  logic                 advance,
  output logic [MEM_AW-1:0]    addr,
  output logic [AXI_LEN_W-1:0] cnt,
  output logic                 last
);

  logic [AXI_LEN_W-1:0] len_r;
  logic                 fixed_r;

  // Burst context and beat counter; address wraps naturally modulo 2^MEM_AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= {MEM_AW{1'b0}};
      cnt     <= {AXI_LEN_W{1'b0}};
      len_r   <= {AXI_LEN_W{1'b0}};
      fixed_r <= 1'b0;
    end else if (load) begin
      addr    <= load_addr;
      cnt     <= {AXI_LEN_W{1'b0}};
      len_r   <= load_len;
      // Reserved encoding 2'b11 and WRAP both behave as INCR here.
      fixed_r <= (load_burst == BURST_FIXED);
    end else if (advance) begin
      if (!fixed_r) begin
        addr <= addr + MEM_AW'(1);
      end
      cnt <= cnt + AXI_LEN_W'(1);
    end
  end

  assign last = (cnt == len_r);

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI4 responder in front of a single-port 32-bit SRAM. Serves one burst at a
// time (read or write), alternating priority between AW and AR when both are
// requested together. Write beats become byte-enabled SRAM writes in the W
// handshake cycle; read beats take a request cycle (RREQ) and a data cycle
// (RDATA), giving one read beat per two cycles.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   S_AW*/S_W*/S_B*    AXI write address, write data and write response
//   S_AR*/S_R*         AXI read address and read data
//   mem_cs/mem_we      SRAM select and per-byte write enable (0 = read)
//   mem_addr/mem_wdata SRAM word address and write data
//   mem_rdata          SRAM read data, valid the cycle after a read select
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int MEM_AW        = 14,
  parameter int RESET_PRIO_RD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`AXI_IDS_BITS-1:0]    S_AWID,
  input  logic [`AXI_ADDR_BITS-1:0]   S_AWAddr,
  input  logic [`AXI_LEN_BITS-1:0]    S_AWLen,
  input  logic [`AXI_SIZE_BITS-1:0]   S_AWSize,
  input  logic [1:0]                  S_AWBurst,
  input  logic                        S_AWValid,
  output logic                        S_AWReady,
  input  logic [`AXI_DATA_BITS-1:0]   S_WData,
  input  logic [`AXI_STRB_BITS-1:0]   S_WStrb,
  input  logic                        S_WLast,
  input  logic                        S_WValid,
  output logic                        S_WReady,
  output logic [`AXI_IDS_BITS-1:0]    S_BID,
  output logic [1:0]                  S_BResp,
  output logic                        S_BValid,
  input  logic                        S_BReady,
  input  logic [`AXI_IDS_BITS-1:0]    S_ARID,
  input  logic [`AXI_ADDR_BITS-1:0]   S_ARAddr,
  input  logic [`AXI_LEN_BITS-1:0]    S_ARLen,
  input  logic [`AXI_SIZE_BITS-1:0]   S_ARSize,
  input  logic [1:0]                  S_ARBurst,
  input  logic                        S_ARValid,
  output logic                        S_ARReady,
  output logic [`AXI_IDS_BITS-1:0]    S_RID,
  output logic [`AXI_DATA_BITS-1:0]   S_RData,
  output logic [1:0]                  S_RResp,
  output logic                        S_RLast,
  output logic                        S_RValid,
  input  logic                        S_RReady,
  output logic                        mem_cs,
  output logic [3:0]                  mem_we,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata
);

  state_e               state_r;
  logic                 prio_rd_r;
  logic [AXI_ID_W-1:0]  id_r;
  logic                 err_r;
  logic                 rfirst_r;   // first cycle of RDATA: SRAM output is live
  logic [31:0]          rdata_r;

  logic                 aw_hs_s;
  logic                 ar_hs_s;
  logic                 w_hs_s;
  logic                 r_hs_s;
  logic                 advance_s;
  logic [MEM_AW-1:0]    addr_s;
  logic [AXI_LEN_W-1:0] cnt_s;
  logic                 last_s;

  // Address bits outside the SRAM window and the size fields carry no meaning here.
  logic unused_s;
  assign unused_s = ^{S_AWSize, S_ARSize,
                      S_AWAddr[`AXI_ADDR_BITS-1:MEM_AW+2], S_AWAddr[1:0],
                      S_ARAddr[`AXI_ADDR_BITS-1:MEM_AW+2], S_ARAddr[1:0], cnt_s};

  // A conflicting request yields to the direction that was not granted last.
  assign aw_hs_s = (state_r == ST_IDLE) && S_AWValid && !(S_ARValid && prio_rd_r);
  assign ar_hs_s = (state_r == ST_IDLE) && S_ARValid && !(S_AWValid && !prio_rd_r);
  assign w_hs_s  = (state_r == ST_WDATA) && S_WValid;
  assign r_hs_s  = (state_r == ST_RDATA) && S_RReady;

  // The final beat needs no advance: the next burst reloads the context.
  assign advance_s = (w_hs_s || r_hs_s) && !last_s;

  axi_burst_addr_gen #(
    .MEM_AW (MEM_AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs_s || ar_hs_s),
    .load_addr  (aw_hs_s ? S_AWAddr[MEM_AW+1:2] : S_ARAddr[MEM_AW+1:2]),
    .load_len   (aw_hs_s ? S_AWLen : S_ARLen),
    .load_burst (aw_hs_s ? S_AWBurst : S_ARBurst),
    .advance    (advance_s),
    .addr       (addr_s),
    .cnt        (cnt_s),
    .last       (last_s)
  );

  // Transaction FSM with arbitration priority, latched ID, error and read data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      prio_rd_r <= (RESET_PRIO_RD != 0);
      id_r      <= {AXI_ID_W{1'b0}};
      err_r     <= 1'b0;
      rfirst_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (aw_hs_s) begin
            id_r      <= S_AWID;
            prio_rd_r <= 1'b1;
            state_r   <= ST_WDATA;
          end else if (ar_hs_s) begin
            id_r      <= S_ARID;
            prio_rd_r <= 1'b0;
            state_r   <= ST_RREQ;
          end
        end
        ST_WDATA: begin
          if (w_hs_s) begin
            // A WLast that disagrees with the beat count is reported, not fatal.
            err_r <= err_r | (S_WLast != last_s);
            if (last_s) begin
              state_r <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (S_BReady) begin
            err_r   <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RREQ: begin
          rfirst_r <= 1'b1;
          state_r  <= ST_RDATA;
        end
        ST_RDATA: begin
          rfirst_r <= 1'b0;
          if (rfirst_r) begin
            rdata_r <= mem_rdata;
          end
          if (r_hs_s) begin
            state_r <= last_s ? ST_IDLE : ST_RREQ;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM strobes: write in the W handshake cycle, read select only in RREQ.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = addr_s;
    mem_wdata = 32'h0000_0000;
    case (state_r)
      ST_WDATA: begin
        if (S_WValid) begin
          mem_cs    = 1'b1;
          mem_we    = S_WStrb;
          mem_wdata = S_WData;
        end else begin
          mem_cs    = 1'b0;
          mem_we    = 4'h0;
        end
      end
      ST_RREQ: begin
        mem_cs = 1'b1;
      end
      default: begin
        mem_cs = 1'b0;
      end
    endcase
  end

  assign S_AWReady = aw_hs_s;
  assign S_ARReady = ar_hs_s;
  assign S_WReady  = (state_r == ST_WDATA);
  assign S_BValid  = (state_r == ST_WRESP);
  assign S_BID     = id_r;
  assign S_BResp   = ((state_r == ST_WRESP) && err_r) ? RESP_SLVERR : RESP_OKAY;
  assign S_RValid  = (state_r == ST_RDATA);
  assign S_RID     = id_r;
  assign S_RResp   = RESP_OKAY;
  assign S_RLast   = (state_r == ST_RDATA) && last_s;
  // SRAM output is live in the first RDATA cycle, then the held copy takes over.
  assign S_RData   = rfirst_r ? mem_rdata : rdata_r;

endmodule
